// File: rtl/pipeline_sequencer_pkg.sv
// rtl/pipeline_sequencer_pkg.sv - stage/state encodings and decoder type indices for the stage sequencer
package pipeline_sequencer_pkg;

    localparam int STAGE_COUNT = 3;
    localparam logic [STAGE_COUNT-1:0] STAGE_IF  = 3'd0;
    localparam logic [STAGE_COUNT-1:0] STAGE_ID  = 3'd1;
    localparam logic [STAGE_COUNT-1:0] STAGE_EX  = 3'd2;
    localparam logic [STAGE_COUNT-1:0] STAGE_MEM = 3'd3;
    localparam logic [STAGE_COUNT-1:0] STAGE_WB  = 3'd4;

    // opcode_type is a one-hot vector indexed by these TYPE_* positions
    localparam int OPCODE_COUNT = 8;
    localparam int TYPE_LDI     = 0;
    localparam int TYPE_ALU     = 1;
    localparam int TYPE_LD_Y    = 2;
    localparam int TYPE_LDS     = 3;
    localparam int TYPE_STS     = 4;
    localparam int TYPE_JMP     = 5;
    localparam int TYPE_BRANCH  = 6;
    localparam int TYPE_NOP     = 7;

    localparam int GROUP_COUNT  = 4;

    typedef enum logic [2:0] {
        SEQ_IF   = 3'd0,
        SEQ_IF2  = 3'd1,
        SEQ_ID   = 3'd2,
        SEQ_EX   = 3'd3,
        SEQ_MEM  = 3'd4,
        SEQ_WB   = 3'd5,
        SEQ_HALT = 3'd6
    } seq_state_t;

    function automatic logic is_mem_op(input logic [OPCODE_COUNT-1:0] op_type);
        return op_type[TYPE_LD_Y] | op_type[TYPE_LDS] | op_type[TYPE_STS];
    endfunction

endpackage

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - three enabled wrapping counters, built only with PERF_COUNTERS_EN
`ifdef PERF_COUNTERS_EN
module perf_counter_bank #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cycle_en,
    input  logic             retire_en,
    input  logic             stall_en,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stalls
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycles  <= '0;
            retired <= '0;
            stalls  <= '0;
        end else begin
            if (cycle_en)  cycles  <= cycles + 1'b1;
            if (retire_en) retired <= retired + 1'b1;
            if (stall_en)  stalls  <= stalls + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - IF/ID/EX/MEM/WB stage sequencer with MEM stall and halt; PERF_COUNTERS_EN adds perf counters
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int STALL_MAX = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    two_word,
    input  logic [OPCODE_COUNT-1:0] opcode_type,
    input  logic [GROUP_COUNT-1:0]  opcode_group,
    input  logic                    mem_ready,
    input  logic                    halt_req,
    output logic [STAGE_COUNT-1:0]  pipeline_stage,
    output logic                    fetch_word2,
    output logic                    pc_inc,
    output logic                    instr_latch,
    output logic                    retire,
    output logic                    halted,
    output logic                    mem_timeout
`ifdef PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]        perf_cycles,
    output logic [CNT_W-1:0]        perf_retired,
    output logic [CNT_W-1:0]        perf_stalls
`endif
);

    localparam int WAIT_W = (STALL_MAX > 1) ? $clog2(STALL_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(STALL_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STALL_MAX - 1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_hold;
    logic              unused_group;

    assign unused_group = ^opcode_group;

    // Only real memory opcodes wait on the bus; everything else passes MEM in one cycle
    assign mem_hold = (state == SEQ_MEM) && is_mem_op(opcode_type) && !mem_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= SEQ_IF;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == SEQ_EX)
                wait_cnt <= '0;
            else if (mem_hold && (wait_cnt != WAIT_SAT))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The pulse marks the held cycle whose increment lands on STALL_MAX; saturation stops repeats
    assign mem_timeout = reset_n && mem_hold && (STALL_MAX != 0) && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt      = SEQ_IF;
        pipeline_stage = STAGE_IF;
        fetch_word2    = 1'b0;
        pc_inc         = 1'b0;
        instr_latch    = 1'b0;
        retire         = 1'b0;
        halted         = 1'b0;
        case (state)
            SEQ_IF: begin
                pc_inc      = 1'b1;
                instr_latch = 1'b1;
                state_nxt   = two_word ? SEQ_IF2 : SEQ_ID;
            end
            SEQ_IF2: begin
                pc_inc      = 1'b1;
                instr_latch = 1'b1;
                fetch_word2 = 1'b1;
                state_nxt   = SEQ_ID;
            end
            SEQ_ID: begin
                pipeline_stage = STAGE_ID;
                state_nxt      = SEQ_EX;
            end
            SEQ_EX: begin
                pipeline_stage = STAGE_EX;
                state_nxt      = SEQ_MEM;
            end
            SEQ_MEM: begin
                pipeline_stage = STAGE_MEM;
                state_nxt      = mem_hold ? SEQ_MEM : SEQ_WB;
            end
            SEQ_WB: begin
                pipeline_stage = STAGE_WB;
                retire         = 1'b1;
                state_nxt      = halt_req ? SEQ_HALT : SEQ_IF;
            end
            SEQ_HALT: begin
                halted    = 1'b1;
                state_nxt = halt_req ? SEQ_HALT : SEQ_IF;
            end
            default: state_nxt = SEQ_IF;
        endcase
        // Outputs read as the reset state while reset_n is low, whatever the register holds
        if (!reset_n) begin
            pipeline_stage = STAGE_IF;
            fetch_word2    = 1'b0;
            pc_inc         = 1'b0;
            instr_latch    = 1'b0;
            retire         = 1'b0;
            halted         = 1'b0;
        end
    end

`ifdef PERF_COUNTERS_EN
    perf_counter_bank #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .reset_n   (reset_n),
        .cycle_en  (1'b1),
        .retire_en (retire),
        .stall_en  (mem_hold),
        .cycles    (perf_cycles),
        .retired   (perf_retired),
        .stalls    (perf_stalls)
    );
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
